isa_timer_bank: RTL and testbench
=================================

// Module: isa_timer_bank
// PURPOSE
//  NUM_CH-channel programmable interval timer on the ISA I/O bus.
//  Successor to the fixed two-divider tick counters: adds per-channel reload, one-shot/periodic mode,
//  free-running readback with an atomic 16-bit snapshot, and write-1-to-clear status with a maskable irq.
//  Bus strobes are synchronised into clk; all state is in the single clk domain.
// PARAMETERS
//  BASE_ADDR  10'h340  first I/O address; channel c occupies BASE_ADDR+4*c .. +4*c+3
//  NUM_CH     4        channel count, 1..8
//  CNT_W      16       counter/reload width, 9..16
//  PRESCALE   1000     clk cycles per timer tick, >=2
// PORTS
//  clk     in   1      system clock
//  rst     in   1      synchronous reset, active high
//  ab      in   10     ISA address
//  aen     in   1      DMA address enable; decode only when 0
//  iow_n   in   1      ISA I/O write strobe, async, active low
//  ior_n   in   1      ISA I/O read strobe, async, active low
//  db_in   in   8      write data
//  db_out  out  8      read data (registered)
//  oe_n    out  1      bus driver enable, 0 = drive db_out
//  irq     out  1      level interrupt, registered
// BEHAVIOUR
//  Reset: db_out=0, irq=0, all reload/count/ctrl/status=0, prescaler=0, shadow=0.
//  Sync: iow_n, ior_n pass 2 flops; edge detect on synced copy.
//  Decode: hit = (aen==0) && ab in [BASE_ADDR, BASE_ADDR+4*NUM_CH-1]; ch = (ab-BASE_ADDR)>>2, reg = ab[1:0].
//  ab/db_in sampled every clk while synced iow_n==0; write commits on synced iow_n rising edge,
//  i.e. 3 clk after raw iow_n rises.
//  Reads: on synced ior_n falling edge db_out <= reg value (2-3 clk after raw fall).
//  oe_n = ior_n | ~hit (combinational).
//  Register map per channel:
//   +0  W: RELOAD[7:0]             R: COUNT[7:0]; same read latches shadow <= COUNT[CNT_W-1:8]
//   +1  W: RELOAD[CNT_W-1:8]       R: shadow (0-padded to 8 bits)
//   +2  W/R: CTRL  bit0 EN, bit1 PERIODIC, bit2 IE; bits7:3 read 0
//   +3  R: STATUS  bit0 EXP        W: 1 in bit0 clears EXP
//  Prescaler: free counter 0..PRESCALE-1; tick=1 for one clk at PRESCALE-1; wraps to 0.
//  Channel per clk, in priority order:
//   1) CTRL write with EN 0->1: COUNT <= RELOAD; no decrement this clk.
//   2) else if EN && tick: COUNT==0 -> EXP<=1; PERIODIC ? COUNT<=RELOAD : EN<=0 (COUNT stays 0);
//      COUNT!=0 -> COUNT<=COUNT-1.
//  Expiry period = (RELOAD+1) ticks; RELOAD=0 expires every tick.
//  RELOAD write while running: no effect on COUNT until next reload.
//  EN cleared by write: COUNT freezes, EXP kept.
//  W1C on EXP in same clk as expiry: EXP stays 1 (set wins).
//  irq <= |(EXP & IE) over channels; 1 clk after EXP/IE change.
//  Decode miss or unused reg bits: writes ignored; reads of miss leave db_out unchanged.
//  rst mid-count: everything returns to reset values next clk; pending bus strobe edges discarded.
// TESTING
//  Reset: rst 2 clk -> db_out=0, irq=0, read all regs = 0.
//  Ch0 RELOAD=3, CTRL=0x07 -> EXP at 4th tick, irq=1 next clk; expiry every 4 ticks; W1C STATUS -> irq=0.
//  Ch1 one-shot: RELOAD=2, CTRL=0x05 -> single EXP after 3 ticks, CTRL reads 0x04, COUNT stays 0.
//  Snapshot: RELOAD=0x0100 running; read +0 returns 0x00 as COUNT goes 0x0100->0x00FF; read +1 returns 0x01.
//  Race: W1C commits in same clk as expiry -> EXP=1, irq stays 1.
//  aen=1 write to BASE_ADDR -> no change; address BASE_ADDR+4*NUM_CH -> oe_n=1, no write.

Source files
------------

// File: rtl/isa_timer_bank.sv
// Multi-channel programmable interval timer on the ISA I/O bus.
// Bus strobes are synchronised into clk; each channel has reload, count, control and W1C status.
module isa_timer_bank #(
    parameter logic [9:0] BASE_ADDR = 10'h340,
    parameter int         NUM_CH    = 4,
    parameter int         CNT_W     = 16,
    parameter int         PRESCALE  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] ab,
    input  logic       aen,
    input  logic       iow_n,
    input  logic       ior_n,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    output logic       oe_n,
    output logic       irq
);

    localparam int         PRE_W     = $clog2(PRESCALE);
    localparam int         HI_W      = CNT_W - 8;
    localparam logic [9:0] LAST_ADDR = BASE_ADDR + 10'(4 * NUM_CH - 1);

    function automatic logic dec_hit(input logic [9:0] a, input logic a_en);
        return (a_en == 1'b0) && (a >= BASE_ADDR) && (a <= LAST_ADDR);
    endfunction

    function automatic logic [2:0] dec_ch(input logic [9:0] a);
        return 3'((a - BASE_ADDR) >> 2);
    endfunction

    // Strobe synchronisers: [0] first stage, [1] synced copy, [2] previous synced value
    logic [2:0] iow_sync_reg;
    logic [2:0] ior_sync_reg;
    logic       iow_rise;
    logic       ior_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            iow_sync_reg <= 3'b111;
            ior_sync_reg <= 3'b111;
        end else begin
            iow_sync_reg <= {iow_sync_reg[1:0], iow_n};
            ior_sync_reg <= {ior_sync_reg[1:0], ior_n};
        end
    end

    assign iow_rise = iow_sync_reg[1] & ~iow_sync_reg[2];
    assign ior_fall = ~ior_sync_reg[1] & ior_sync_reg[2];

    // Address/data captured while the write strobe is low so the commit uses stable values
    logic [9:0] wr_ab_reg;
    logic       wr_aen_reg;
    logic [7:0] wr_data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ab_reg   <= '0;
            wr_aen_reg  <= 1'b0;
            wr_data_reg <= '0;
        end else if (!iow_sync_reg[1]) begin
            wr_ab_reg   <= ab;
            wr_aen_reg  <= aen;
            wr_data_reg <= db_in;
        end
    end

    logic       wr_hit;
    logic [2:0] wr_ch;
    logic [1:0] wr_sel;
    logic       rd_hit;
    logic [2:0] rd_ch;
    logic [1:0] rd_sel;

    assign wr_hit = iow_rise && dec_hit(wr_ab_reg, wr_aen_reg);
    assign wr_ch  = dec_ch(wr_ab_reg);
    assign wr_sel = wr_ab_reg[1:0];
    assign rd_hit = ior_fall && dec_hit(ab, aen);
    assign rd_ch  = dec_ch(ab);
    assign rd_sel = ab[1:0];
    assign oe_n   = ior_n | ~dec_hit(ab, aen);

    // Shared prescaler; tick is high for the single clk where the counter sits at its top value
    logic [PRE_W-1:0] pre_reg;
    logic             tick;

    assign tick = (pre_reg == PRE_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_reg <= '0;
        end else if (tick) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + PRE_W'(1);
        end
    end

    logic [NUM_CH-1:0][7:0] ch_rd_all;
    logic [NUM_CH-1:0]      exp_all;
    logic [NUM_CH-1:0]      ie_all;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : ch_g
            logic [CNT_W-1:0] reload_reg;
            logic [CNT_W-1:0] count_reg;
            logic [2:0]       ctrl_reg;
            logic             exp_reg;
            logic [HI_W-1:0]  shadow_reg;
            logic             wr_this;
            logic             rd_this;
            logic             start;
            logic             expire;

            assign wr_this = wr_hit && (wr_ch == 3'(gi));
            assign rd_this = rd_hit && (rd_ch == 3'(gi));
            assign start   = wr_this && (wr_sel == 2'd2) && wr_data_reg[0] && !ctrl_reg[0];
            assign expire  = !start && ctrl_reg[0] && tick && (count_reg == '0);

            always_ff @(posedge clk) begin
                if (rst) begin
                    reload_reg <= '0;
                    count_reg  <= '0;
                    ctrl_reg   <= '0;
                    exp_reg    <= 1'b0;
                    shadow_reg <= '0;
                end else begin
                    if (wr_this && wr_sel == 2'd0) begin
                        reload_reg[7:0] <= wr_data_reg;
                    end
                    if (wr_this && wr_sel == 2'd1) begin
                        reload_reg[CNT_W-1:8] <= wr_data_reg[HI_W-1:0];
                    end

                    if (start) begin
                        count_reg <= reload_reg;
                    end else if (ctrl_reg[0] && tick) begin
                        if (count_reg == '0) begin
                            if (ctrl_reg[1]) begin
                                count_reg <= reload_reg;
                            end
                        end else begin
                            count_reg <= count_reg - CNT_W'(1);
                        end
                    end

                    // A bus write to CTRL takes precedence over the one-shot self-disable
                    if (wr_this && wr_sel == 2'd2) begin
                        ctrl_reg <= wr_data_reg[2:0];
                    end else if (expire && !ctrl_reg[1]) begin
                        ctrl_reg[0] <= 1'b0;
                    end

                    // Expiry wins over a W1C landing in the same clk
                    if (expire) begin
                        exp_reg <= 1'b1;
                    end else if (wr_this && wr_sel == 2'd3 && wr_data_reg[0]) begin
                        exp_reg <= 1'b0;
                    end

                    if (rd_this && rd_sel == 2'd0) begin
                        shadow_reg <= count_reg[CNT_W-1:8];
                    end
                end
            end

            assign ch_rd_all[gi] = (rd_sel == 2'd0) ? count_reg[7:0]   :
                                   (rd_sel == 2'd1) ? 8'(shadow_reg)   :
                                   (rd_sel == 2'd2) ? {5'b0, ctrl_reg} :
                                                      {7'b0, exp_reg};
            assign exp_all[gi]   = exp_reg;
            assign ie_all[gi]    = ctrl_reg[2];
        end
    endgenerate

    logic [7:0] rd_data;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == 3'(i)) begin
                rd_data = ch_rd_all[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_out <= '0;
            irq    <= 1'b0;
        end else begin
            if (rd_hit) begin
                db_out <= rd_data;
            end
            irq <= |(exp_all & ie_all);
        end
    end

endmodule

// File: tb/tb_isa_timer_bank.sv
// Bench for isa_timer_bank: bus reads checked through a scoreboard queue,
// timer expiry timing predicted from the prescaler period and the bus commit clk.
module tb_isa_timer_bank;

    localparam logic [9:0] BASE = 10'h340;
    localparam int         NCH  = 4;
    localparam int         P    = 16;

    logic       clk;
    logic       rst;
    logic [9:0] ab;
    logic       aen;
    logic       iow_n;
    logic       ior_n;
    logic [7:0] db_in;
    logic [7:0] db_out;
    logic       oe_n;
    logic       irq;

    isa_timer_bank #(
        .BASE_ADDR(BASE),
        .NUM_CH   (NCH),
        .CNT_W    (16),
        .PRESCALE (P)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ab    (ab),
        .aen   (aen),
        .iow_n (iow_n),
        .ior_n (ior_n),
        .db_in (db_in),
        .db_out(db_out),
        .oe_n  (oe_n),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index since reset release; tick edges are the multiples of P
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int total = 0;
    int bad   = 0;
    int ebase = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc < target && guard < 5000) begin
            step(1);
            guard++;
        end
        chk("align", 32'(cyc), 32'(target));
    endtask

    task automatic wait_irq(input logic val, output int at);
        int n = 0;
        while (irq !== val && n < 400) begin
            step(1);
            n++;
        end
        at = (irq === val) ? cyc : -1;
    endtask

    function automatic int first_tick_after(input int c);
        return (c / P + 1) * P;
    endfunction

    function automatic int next_exp(input int x);
        int e = ebase;
        while (e < x) e += 4 * P;
        return e;
    endfunction

    function automatic int prev_exp(input int x);
        int e = ebase;
        while (e + 4 * P <= x) e += 4 * P;
        return e;
    endfunction

    task automatic wr_begin(input logic [9:0] addr, input logic [7:0] data, input logic aen_v);
        ab    = addr;
        db_in = data;
        aen   = aen_v;
        iow_n = 1'b0;
        step(3);
    endtask

    task automatic wr_end(output int commit);
        iow_n  = 1'b1;
        commit = cyc + 3;
        step(4);
        $display("wr addr=%h data=%h aen=%0d commit=%0d", ab, db_in, aen, commit);
        aen = 1'b0;
    endtask

    task automatic bus_wr(input logic [9:0] addr, input logic [7:0] data, input logic aen_v);
        int c;
        wr_begin(addr, data, aen_v);
        wr_end(c);
    endtask

    task automatic bus_rd(input logic [9:0] addr, input logic aen_v, input logic exp_oe,
                          input logic [7:0] exp_val, input string tag);
        exp_t e;
        sb_q.push_back('{tag, exp_val});
        ab    = addr;
        aen   = aen_v;
        ior_n = 1'b0;
        step(1);
        chk({tag, "_oe"}, 32'(oe_n), 32'(exp_oe));
        step(3);
        e = sb_q.pop_front();
        chk(e.tag, 32'(db_out), 32'(e.val));
        $display("rd addr=%h aen=%0d data=%h want=%h", addr, aen_v, db_out, e.val);
        ior_n = 1'b1;
        aen   = 1'b0;
        step(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, t1, at, cc, e, cr, cd, fc, c1, tt;
        rst = 1'b1; ab = '0; aen = 1'b0; iow_n = 1'b1; ior_n = 1'b1; db_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_db_out", 32'(db_out), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_oe_n", 32'(oe_n), 1);
        for (int ch = 0; ch < NCH; ch++) begin
            for (int r = 0; r < 4; r++) begin
                bus_rd(BASE + 10'(4 * ch + r), 1'b0, 1'b0, 8'h00, "rst_reg");
            end
        end

        // Channel 0: periodic, reload 3, irq enabled
        bus_wr(BASE + 10'd0, 8'h03, 1'b0);
        bus_wr(BASE + 10'd1, 8'h00, 1'b0);
        wr_begin(BASE + 10'd2, 8'h07, 1'b0);
        wr_end(c0);
        t1    = first_tick_after(c0);
        ebase = t1 + 3 * P;
        wait_irq(1'b1, at);
        chk("ch0_first_irq_cyc", 32'(at), 32'(ebase + 1));
        bus_rd(BASE + 10'd3, 1'b0, 1'b0, 8'h01, "ch0_status");
        wr_begin(BASE + 10'd3, 8'h01, 1'b0);
        wr_end(cc);
        chk("ch0_w1c_irq", 32'(irq), 0);
        wait_irq(1'b1, at);
        chk("ch0_period_cyc", 32'(at), 32'(next_exp(cc) + 1));

        // Clear again, then land a W1C on the exact expiry clk
        bus_wr(BASE + 10'd3, 8'h01, 1'b0);
        chk("ch0_w1c2_irq", 32'(irq), 0);
        e = next_exp(cyc + 6);
        wr_begin(BASE + 10'd3, 8'h01, 1'b0);
        wait_cyc(e - 3);
        wr_end(cr);
        chk("race_irq", 32'(irq), 1);
        bus_rd(BASE + 10'd3, 1'b0, 1'b0, 8'h01, "race_status");

        // Disable: count freezes, EXP kept
        wr_begin(BASE + 10'd2, 8'h00, 1'b0);
        wr_end(cd);
        chk("dis_irq", 32'(irq), 0);
        fc = 3 - (cd / P - prev_exp(cd) / P);
        step(2 * P);
        bus_rd(BASE + 10'd0, 1'b0, 1'b0, 8'(fc), "ch0_frozen");
        bus_rd(BASE + 10'd3, 1'b0, 1'b0, 8'h01, "ch0_exp_kept");

        // Channel 1: one-shot, reload 2
        bus_wr(BASE + 10'd4, 8'h02, 1'b0);
        bus_wr(BASE + 10'd5, 8'h00, 1'b0);
        wr_begin(BASE + 10'd6, 8'h05, 1'b0);
        wr_end(c1);
        t1 = first_tick_after(c1);
        wait_irq(1'b1, at);
        chk("ch1_irq_cyc", 32'(at), 32'(t1 + 2 * P + 1));
        bus_rd(BASE + 10'd6, 1'b0, 1'b0, 8'h04, "ch1_ctrl");
        bus_rd(BASE + 10'd4, 1'b0, 1'b0, 8'h00, "ch1_count");
        step(2 * P);
        bus_rd(BASE + 10'd4, 1'b0, 1'b0, 8'h00, "ch1_count_hold");
        bus_rd(BASE + 10'd7, 1'b0, 1'b0, 8'h01, "ch1_status");
        bus_wr(BASE + 10'd7, 8'h01, 1'b0);
        chk("ch1_w1c_irq", 32'(irq), 0);
        step(2 * P);
        chk("ch1_quiet_irq", 32'(irq), 0);

        // Channel 2: snapshot of the high byte across 0x0100 -> 0x00FF
        bus_wr(BASE + 10'd8, 8'h00, 1'b0);
        bus_wr(BASE + 10'd9, 8'h01, 1'b0);
        wr_begin(BASE + 10'd10, 8'h01, 1'b0);
        tt = first_tick_after(cyc + 3) + 1;
        wait_cyc(tt - 3);
        wr_end(c0);
        bus_rd(BASE + 10'd8, 1'b0, 1'b0, 8'h00, "snap_lo");
        wait_cyc(tt + P);
        bus_rd(BASE + 10'd9, 1'b0, 1'b0, 8'h01, "snap_hi");
        bus_rd(BASE + 10'd8, 1'b0, 1'b0, 8'hFF, "snap_lo2");
        bus_rd(BASE + 10'd9, 1'b0, 1'b0, 8'h00, "snap_hi2");

        // Decode misses
        bus_wr(BASE + 10'd2, 8'h07, 1'b1);
        bus_rd(BASE + 10'd2, 1'b0, 1'b0, 8'h00, "aen_wr_ignored");
        bus_rd(BASE + 10'd6, 1'b0, 1'b0, 8'h04, "ch1_ctrl_again");
        bus_wr(BASE + 10'(4 * NCH), 8'hFF, 1'b0);
        bus_rd(BASE + 10'(4 * NCH), 1'b0, 1'b1, 8'h04, "miss_rd");
        bus_rd(BASE, 1'b1, 1'b1, 8'h04, "aen_rd");
        bus_rd(BASE + 10'd2, 1'b0, 1'b0, 8'h00, "ch0_ctrl_after_miss");

        // Reset while channel 2 is counting
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_irq", 32'(irq), 0);
        chk("midrst_db_out", 32'(db_out), 0);
        bus_rd(BASE + 10'd10, 1'b0, 1'b0, 8'h00, "midrst_ch2_ctrl");
        bus_rd(BASE + 10'd3, 1'b0, 1'b0, 8'h00, "midrst_ch0_status");
        bus_rd(BASE + 10'd8, 1'b0, 1'b0, 8'h00, "midrst_ch2_count");
        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
